// File: rtl/riscv_hwloop_jump_ctrl_pkg.sv
// Shared types for the hardware-loop jump controller and its priority matcher.
package riscv_hwloop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } hwlp_state_e;

    localparam int HWLP_DEFAULT_N_REGS = 2;

endpackage

// File: rtl/riscv_hwloop_jump_ctrl_if.sv
// ID/fetch/loop-register bundle seen by the jump controller.
// RISCV_HWLOOP_PERF_EN adds the accepted-jump counter output.
interface riscv_hwloop_jump_ctrl_if
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS = HWLP_DEFAULT_N_REGS
);
    logic [31:0]             current_pc_i;
    logic                    pc_valid_i;
    logic                    id_valid_i;
    logic                    flush_i;
    logic                    fetch_ready_i;
    logic [N_REGS-1:0][31:0] hwlp_start_addr_i;
    logic [N_REGS-1:0][31:0] hwlp_end_addr_i;
    logic [N_REGS-1:0][31:0] hwlp_counter_i;
    logic                    hwlp_jump_o;
    logic [31:0]             hwlp_targ_addr_o;
    logic [N_REGS-1:0]       hwlp_dec_cnt_o;
    logic                    hwlp_busy_o;
`ifdef RISCV_HWLOOP_PERF_EN
    logic [31:0]             perf_jump_cnt_o;
`endif

    modport master (
        input  current_pc_i, pc_valid_i, id_valid_i, flush_i, fetch_ready_i,
        input  hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i,
`ifdef RISCV_HWLOOP_PERF_EN
        output perf_jump_cnt_o,
`endif
        output hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o, hwlp_busy_o
    );

    modport slave (
        output current_pc_i, pc_valid_i, id_valid_i, flush_i, fetch_ready_i,
        output hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i,
`ifdef RISCV_HWLOOP_PERF_EN
        input  perf_jump_cnt_o,
`endif
        input  hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o, hwlp_busy_o
    );

endinterface

// File: rtl/riscv_hwloop_jump_ctrl_match.sv
// Combinational end-address matcher; the lowest matching loop index wins.
module riscv_hwloop_match
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS     = HWLP_DEFAULT_N_REGS,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic [31:0]             i_pc,
    input  logic                    i_pc_valid,
    input  logic [N_REGS-1:0][31:0] i_end_addr,
    input  logic [N_REGS-1:0][31:0] i_counter,
    output logic                    o_hit,
    output logic                    o_jump,
    output logic [N_REG_BITS-1:0]   o_idx,
    output logic [N_REGS-1:0]       o_onehot
);

    // Scan from the outermost loop down so the innermost match overrides.
    always_comb begin
        o_hit    = 1'b0;
        o_jump   = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (i_pc_valid && (i_pc == i_end_addr[k]) && (i_counter[k] != 32'd0)) begin
                o_hit       = 1'b1;
                o_jump      = (i_counter[k] > 32'd1);
                o_idx       = N_REG_BITS'(k);
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_hwloop_jump_ctrl.sv
// Hardware-loop jump/decrement controller on the ID side of the loop registers.
// RISCV_HWLOOP_PERF_EN adds a saturating count of jumps accepted by fetch.
module riscv_hwloop_jump_ctrl
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS     = HWLP_DEFAULT_N_REGS,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    riscv_hwloop_jump_ctrl_if.master bus
);
    // state | meaning
    // IDLE  | matching end addresses, jump/decrement issued combinationally
    // HOLD  | jump not yet accepted by fetch, latched target replayed
    // DONE  | jump accepted, end instruction still stalled in ID

    hwlp_state_e             r_state, w_state_nxt;
    logic [31:0]             r_targ, w_targ_nxt;
    logic [N_REGS-1:0]       r_onehot, w_onehot_nxt;
    logic                    r_dec_done, w_dec_done_nxt;

    logic                    w_hit;
    logic                    w_jump_hit;
    logic [N_REG_BITS-1:0]   w_idx;
    logic [N_REGS-1:0]       w_onehot;
    logic [31:0]             w_start_sel;

    riscv_hwloop_match #(
        .N_REGS     (N_REGS),
        .N_REG_BITS (N_REG_BITS)
    ) u_match (
        .i_pc       (bus.current_pc_i),
        .i_pc_valid (bus.pc_valid_i),
        .i_end_addr (bus.hwlp_end_addr_i),
        .i_counter  (bus.hwlp_counter_i),
        .o_hit      (w_hit),
        .o_jump     (w_jump_hit),
        .o_idx      (w_idx),
        .o_onehot   (w_onehot)
    );

    assign w_start_sel = bus.hwlp_start_addr_i[w_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_targ     <= '0;
            r_onehot   <= '0;
            r_dec_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_targ     <= w_targ_nxt;
            r_onehot   <= w_onehot_nxt;
            r_dec_done <= w_dec_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_targ_nxt           = r_targ;
        w_onehot_nxt         = r_onehot;
        w_dec_done_nxt       = r_dec_done;
        bus.hwlp_jump_o      = 1'b0;
        bus.hwlp_targ_addr_o = '0;
        bus.hwlp_dec_cnt_o   = '0;

        if (bus.flush_i) begin
            w_state_nxt    = IDLE;
            w_targ_nxt     = '0;
            w_onehot_nxt   = '0;
            w_dec_done_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        bus.hwlp_dec_cnt_o = w_onehot;
                        if (w_jump_hit) begin
                            bus.hwlp_jump_o      = 1'b1;
                            bus.hwlp_targ_addr_o = w_start_sel;
                            if (!bus.fetch_ready_i) begin
                                w_state_nxt    = HOLD;
                                w_targ_nxt     = w_start_sel;
                                w_onehot_nxt   = w_onehot;
                                w_dec_done_nxt = bus.id_valid_i;
                            end else if (!bus.id_valid_i) begin
                                w_state_nxt  = DONE;
                                w_onehot_nxt = w_onehot;
                            end
                        end
                    end
                end
                HOLD: begin
                    bus.hwlp_jump_o      = 1'b1;
                    bus.hwlp_targ_addr_o = r_targ;
                    if (!r_dec_done) begin
                        bus.hwlp_dec_cnt_o = r_onehot;
                    end
                    if (bus.id_valid_i) begin
                        w_dec_done_nxt = 1'b1;
                    end
                    if (bus.fetch_ready_i) begin
                        if (r_dec_done || bus.id_valid_i) begin
                            w_state_nxt    = IDLE;
                            w_targ_nxt     = '0;
                            w_onehot_nxt   = '0;
                            w_dec_done_nxt = 1'b0;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    bus.hwlp_dec_cnt_o = r_onehot;
                    if (bus.id_valid_i) begin
                        w_state_nxt    = IDLE;
                        w_targ_nxt     = '0;
                        w_onehot_nxt   = '0;
                        w_dec_done_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.hwlp_busy_o = (r_state != IDLE);

`ifdef RISCV_HWLOOP_PERF_EN
    logic [31:0] r_perf_cnt;
    logic        w_accept;

    assign w_accept = bus.hwlp_jump_o && bus.fetch_ready_i && !bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt <= '0;
        end else if (w_accept && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign bus.perf_jump_cnt_o = r_perf_cnt;
`endif

endmodule
